// File: rtl/spi_command_decoder.sv
// spi_command_decoder
// SPI (mode 0) slave front end for the spiking network configuration memory.
// SCLK/MOSI/SS are oversampled in the system_clock domain. Bytes are assembled
// MSB-first and decoded as WRITE (0x01 addr data) or READ (0x02 addr dummy)
// instructions that drive a single-port memory access.
//
// Ports:
//   system_clock          sole clock, rising edge
//   rst_n                 asynchronous active-low reset
//   SCLK, MOSI, SS        raw SPI pins (asynchronous, SS active low)
//   MISO                  registered SPI data out, 0 outside the read data byte
//   mem_addr/mem_wdata    registered memory address / write data
//   mem_we / mem_re       one-cycle write / read strobes (never together)
//   mem_rdata             read data, valid one cycle after mem_re
//   spi_instruction_done  one-cycle pulse when an instruction completes
//   busy                  high from the first opcode bit until back in idle
//
// Build option: define SPI_AUTO_INCREMENT_EN to make further bytes after a
// completed instruction continue writing/reading at consecutive addresses.
module spi_command_decoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              system_clock,
  input  logic              rst_n,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS,
  output logic              MISO,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              spi_instruction_done,
  output logic              busy
);

  typedef enum logic [3:0] {
    StIdle, StOpcode, StWAddr, StWData, StWTail,
    StRAddr, StRWait, StRLoad, StRData, StRTail, StIgnore
  } state_e;

  logic r_sclk_meta, r_sclk_sync, r_sclk_dly;
  logic r_mosi_meta, r_mosi_sync;
  logic r_ss_meta, r_ss_sync, r_ss_dly;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  state_e r_state;
  logic [DATA_W-1:0] r_tx;
  logic r_miso, r_we, r_re, r_done, r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_rise, w_fall, w_ss_fall, w_byte;
  logic [7:0] w_byte_val;
  logic [2:0] w_cnt_d;
  state_e w_state_d;
  logic [DATA_W-1:0] w_tx_d, w_wdata_d;
  logic [ADDR_W-1:0] w_addr_d;
  logic w_miso_d, w_we_d, w_re_d, w_done_d, w_busy_d;

  // SS flops reset to 0 (selected) so that SS already low at reset release is
  // not seen as a falling edge: a transfer in flight is never resumed.
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_dly  <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_ss_meta   <= 1'b0;
      r_ss_sync   <= 1'b0;
      r_ss_dly    <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_rx        <= 7'd0;
    end else begin
      r_sclk_meta <= SCLK;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_dly  <= r_sclk_sync;
      r_mosi_meta <= MOSI;
      r_mosi_sync <= r_mosi_meta;
      r_ss_meta   <= SS;
      r_ss_sync   <= r_ss_meta;
      r_ss_dly    <= r_ss_sync;
      r_bit_cnt   <= w_cnt_d;
      if (w_rise) r_rx <= {r_rx[5:0], r_mosi_sync};
    end
  end

  assign w_rise     = r_sclk_sync & ~r_sclk_dly;
  assign w_fall     = ~r_sclk_sync & r_sclk_dly;
  assign w_ss_fall  = ~r_ss_sync & r_ss_dly;
  assign w_byte_val = {r_rx, r_mosi_sync};
  assign w_byte     = w_rise && !r_ss_sync && (r_state != StIdle) && (r_bit_cnt == 3'd7);

  always_comb begin
    w_cnt_d = r_bit_cnt;
    if (r_ss_sync || r_state == StIdle) w_cnt_d = 3'd0;
    else if (w_rise)                    w_cnt_d = r_bit_cnt + 3'd1;
  end

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_tx_d    = r_tx;
    w_we_d    = 1'b0;
    w_re_d    = 1'b0;
    w_done_d  = 1'b0;
    // Shift only on falls inside a byte; the fall that follows a byte's 8th
    // rise (count back at 0) precedes the first bit of the read data.
    if (r_state == StRData && w_fall && r_bit_cnt != 3'd0) begin
      w_tx_d = {r_tx[DATA_W-2:0], 1'b0};
    end
    unique case (r_state)
      StIdle:   if (w_ss_fall) w_state_d = StOpcode;
      StOpcode: begin
        if (w_byte) begin
          if (w_byte_val == 8'h01)      w_state_d = StWAddr;
          else if (w_byte_val == 8'h02) w_state_d = StRAddr;
          else                          w_state_d = StIgnore;
        end
      end
      StWAddr: begin
        if (w_byte) begin
          w_addr_d  = w_byte_val[ADDR_W-1:0];
          w_state_d = StWData;
        end
      end
      StWData: begin
        if (w_byte) begin
          w_wdata_d = w_byte_val;
          w_we_d    = 1'b1;
          w_done_d  = 1'b1;
          w_state_d = StWTail;
        end
      end
      StWTail: begin
`ifdef SPI_AUTO_INCREMENT_EN
        if (w_byte) begin
          w_addr_d  = r_addr + ADDR_W'(1);
          w_wdata_d = w_byte_val;
          w_we_d    = 1'b1;
          w_done_d  = 1'b1;
        end
`endif
      end
      StRAddr: begin
        if (w_byte) begin
          w_addr_d  = w_byte_val[ADDR_W-1:0];
          w_re_d    = 1'b1;
          w_state_d = StRWait;
        end
      end
      StRWait: w_state_d = StRLoad;  // mem_re is high this cycle
      StRLoad: begin                 // mem_rdata is valid this cycle
        w_tx_d    = mem_rdata;
        w_state_d = StRData;
      end
      StRData: begin
        if (w_byte) begin
          w_done_d = 1'b1;
`ifdef SPI_AUTO_INCREMENT_EN
          // Prefetch the next word so it is ready before the next byte.
          w_addr_d  = r_addr + ADDR_W'(1);
          w_re_d    = 1'b1;
          w_state_d = StRWait;
`else
          w_state_d = StRTail;
`endif
        end
      end
      StRTail, StIgnore: begin
      end
      default: w_state_d = StIdle;
    endcase
    // SS deselect aborts from any state; w_byte is already masked by SS.
    if (r_ss_sync && r_state != StIdle) w_state_d = StIdle;
    w_miso_d = (w_state_d == StRData) ? w_tx_d[DATA_W-1] : 1'b0;
    w_busy_d = (w_state_d != StIdle) && !(w_state_d == StOpcode && w_cnt_d == 3'd0);
  end

  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_tx    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_miso  <= 1'b0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_tx    <= w_tx_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_miso  <= w_miso_d;
      r_we    <= w_we_d;
      r_re    <= w_re_d;
      r_done  <= w_done_d;
      r_busy  <= w_busy_d;
    end
  end

  assign MISO                 = r_miso;
  assign mem_addr             = r_addr;
  assign mem_wdata            = r_wdata;
  assign mem_we               = r_we;
  assign mem_re               = r_re;
  assign spi_instruction_done = r_done;
  assign busy                 = r_busy;

endmodule

// File: doc/spi_command_decoder.md
# spi_command_decoder

SPI slave front end for the spiking network: oversamples the external SCLK/MOSI/SS pins in the `system_clock` domain, assembles bytes, and decodes WRITE/READ instructions into a single-port access on the network configuration memory (weights, delays, thresholds). It sits directly upstream of the configuration memory and network core inside `spiking_network_top`. It drives MISO and the `spi_instruction_done` strobe seen at the chip pins.

## Interface
Parameters:
- `ADDR_W`, 8: configuration memory address width; one SPI address byte, so `ADDR_W` ≤ 8.
- `DATA_W`, 8: memory word width; fixed at one SPI byte.

Ports:
- `system_clock`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SCLK`  in  1  SPI clock, asynchronous to `system_clock`, mode 0.
- `MOSI`  in  1  SPI data in, asynchronous.
- `SS`  in  1  slave select, active low, asynchronous.
- `MISO`  out  1  SPI data out, registered.
- `mem_addr`  out  ADDR_W  memory address, registered.
- `mem_wdata`  out  8  memory write data, registered.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_re`  out  1  one-cycle read strobe.
- `mem_rdata`  in  8  read data, valid one cycle after `mem_re`.
- `spi_instruction_done`  out  1  one-cycle pulse when an instruction completes.
- `busy`  out  1  high from the first opcode bit until return to IDLE.

## Operation
- SCLK, MOSI, SS each pass through a 2-flop synchronizer. A third SCLK flop gives rise and fall detection.
- Bit counter 0..7 counts detected SCLK rises while SS is low. MOSI is sampled MSB-first on each rise. The byte is complete on the 8th rise, and the counter wraps to 0.
- States:
  - IDLE: waits for SS low, then goes to OPCODE.
  - OPCODE, first byte: 0x01 goes to W_ADDR. 0x02 goes to R_ADDR. Any other value goes to IGNORE.
  - W_ADDR goes to W_DATA. On the W_DATA byte, assert `mem_we` with `mem_addr` and `mem_wdata`, pulse done, go to TAIL.
  - R_ADDR: on its byte, assert `mem_re`. Load `mem_rdata` into the TX shift register the next cycle, then go to R_DATA. During the R_DATA byte, MISO shifts out MSB-first. Completion of the 8th rise pulses done and goes to TAIL.
  - TAIL and IGNORE: discard further bytes (see Configuration).
  - From any state, synchronized SS high returns to IDLE, clears the bit counter and sets MISO to 0. A partial byte is dropped and causes no memory access.
- MISO: the MSB of the TX register is driven once it is loaded. The TX register shifts left on each detected SCLK fall during R_DATA. MISO is 0 in all other states.
- `mem_addr` holds its last value between accesses. `mem_we` and `mem_re` are never high together.

## Timing
- Reset values: MISO 0, `mem_addr` 0, `mem_wdata` 0, `mem_we` 0, `mem_re` 0, `spi_instruction_done` 0, `busy` 0, state IDLE.
- Edge-to-detect latency is 3 `system_clock` cycles.
- `mem_we`, `mem_re` and done assert 1 cycle after the 8th rise is detected.
- TX is loaded 2 cycles after the `mem_re` cycle. MISO bit 7 is therefore stable 6 cycles after the 8th address rise.
- Requirement: SCLK half-period ≥ 8 `system_clock` cycles (f_SCLK ≤ f_clk/16). Bit 7 then precedes the first R_DATA rise by ≥ 2 cycles.
- The SS high/low setup to SCLK is ≥ 4 cycles.
- If SS rises in the same cycle as the 8th rise is detected, the SS abort wins and no access occurs.
- `rst_n` asserted mid-transfer clears all outputs immediately. After release, the block waits for the next SS falling edge, so a transfer already in progress is not resumed.

## Configuration
- `SPI_AUTO_INCREMENT_EN` defined: in TAIL after a write, each further complete byte writes to `mem_addr`+1, wrapping modulo 2^ADDR_W. Each such write pulses `mem_we` and done.
  - In TAIL after a read, each further byte is preceded by a read at `mem_addr`+1, and that data is shifted out. This requires ≥ 8 cycles between bytes.
- Not defined: TAIL ignores all bytes until SS rises. MISO stays 0.

## Test plan
- Reset with SS high: all outputs 0 and `busy` 0. Assert `rst_n` low mid-byte: outputs clear asynchronously.
- SS low, send 0x01 0x2A 0x5C, SS high → exactly one `mem_we` with `mem_addr`=0x2A and `mem_wdata`=0x5C. One done pulse.
- Memory model holds 0xA3 at 0x10. Send 0x02 0x10 0x00 → one `mem_re` with addr 0x10. MISO bits are 1,0,1,0,0,0,1,1. Done pulses after the 8th bit.
- Send 0x01 0x33, then 4 bits, then SS high → no `mem_we`, no done, state IDLE. The next full write succeeds normally.
- Opcode 0x7F then 2 bytes → no memory strobes, MISO 0, no done.
- With `SPI_AUTO_INCREMENT_EN`: send 0x01 0xFF 0x11 0x22 → writes 0x11 at 0xFF and 0x22 at 0x00. Without it, only the first write occurs.
